// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
//   Shared definitions for the multiplier product-combine slice.
//
//   PROD_W     full product width (64 for 32x32 operands)
//   MUL_TAG_W  destination-register tag width used by the stage-A bundle
//   MID_W      width of the cross-term sum p2+p3 (two extra bits so the
//              carry survives for uu and the sign survives for ss)
//   SEL_LO/HI  word-select encoding for the returned 32-bit result
//   stage_a_t  register bundle held between the two pipeline stages
//   select_word  picks the low or high 32-bit word of a full product
// ---------------------------------------------------------------------------
package mul_pkg;

  localparam int PROD_W    = 64;
  localparam int MUL_TAG_W = 5;
  localparam int MID_W     = 34;
  localparam int WORD_W    = 32;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  typedef struct packed {
    logic [MID_W-1:0]     mid;
    logic [PROD_W-1:0]    hilo;
    logic                 sel_hi;
    logic [MUL_TAG_W-1:0] tag;
    logic                 valid;
  } stage_a_t;

  function automatic logic [WORD_W-1:0] select_word(
    input logic [PROD_W-1:0] product,
    input logic              sel
  );
    logic [WORD_W-1:0] word;
    word = product[WORD_W-1:0];
    case (sel)
      SEL_HI: word = product[PROD_W-1:WORD_W];
      SEL_LO: word = product[WORD_W-1:0];
      default: word = product[WORD_W-1:0];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/mul_mid_sum.sv
// ---------------------------------------------------------------------------
// mul_mid_sum
//   Combinational sign-aware adder for the two cross partial products of a
//   32x32 multiply built from 16x16 cells. Each 32-bit term is widened to
//   34 bits, sign-extended when the corresponding operand half was signed
//   and zero-extended otherwise, then the two are summed.
//
//   Ports
//     p2         lo(src1) * hi(src2) partial product
//     p3         hi(src1) * lo(src2) partial product
//     p2_signed  p2 is a signed quantity (follows src2 signedness)
//     p3_signed  p3 is a signed quantity (follows src1 signedness)
//     mid        34-bit two's-complement sum of the extended terms
// ---------------------------------------------------------------------------
module mul_mid_sum
  import mul_pkg::*;
(
  input  logic [WORD_W-1:0] p2,
  input  logic [WORD_W-1:0] p3,
  input  logic              p2_signed,
  input  logic              p3_signed,
  output logic [MID_W-1:0]  mid
);

  logic [MID_W-1:0] p2_ext;
  logic [MID_W-1:0] p3_ext;

  // Two extension bits: one absorbs the carry of an unsigned sum, the other
  // keeps the result interpretable as a signed 34-bit value in every mode.
  always_comb begin
    p2_ext = {{(MID_W-WORD_W){p2_signed & p2[WORD_W-1]}}, p2};
    p3_ext = {{(MID_W-WORD_W){p3_signed & p3[WORD_W-1]}}, p3};
    mid    = p2_ext + p3_ext;
  end

endmodule

// File: rtl/mul_product_combine.sv
// ---------------------------------------------------------------------------
// mul_product_combine
//   Two-stage pipeline that folds the four registered 16x16 partial products
//   of a 32x32 multiply into the 64-bit product and returns either word.
//
//   Stage A : mid = sx(p2) + sx(p3); also holds {p4,p1}, sel_hi, tag, valid
//   Stage 2 : product = {p4,p1} + (sign-extend(mid) << 16), word select
//
//   Ports
//     clk, reset_n     core clock, synchronous active-low reset
//     in_valid         partial products and controls valid this cycle
//     in_src1_signed   src1 signed (governs p3 extension)
//     in_src2_signed   src2 signed (governs p2 extension)
//     in_sel_hi        1 returns product[63:32], 0 returns product[31:0]
//     in_tag           destination register tag
//     in_p1..in_p4     lo*lo, lo*hi, hi*lo, hi*hi partial products
//     stall            hold every register, ignore inputs
//     flush            drop all in-flight ops and the incoming op
//     out_valid        result valid
//     out_result       selected 32-bit word
//     out_product      full 64-bit product
//     out_tag          tag travelling with the result
//     busy             any stage holds a valid op
// ---------------------------------------------------------------------------
module mul_product_combine #(
  parameter int TAG_W  = 5,
  parameter int PROD_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_src1_signed,
  input  logic              in_src2_signed,
  input  logic              in_sel_hi,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [31:0]       in_p1,
  input  logic [31:0]       in_p2,
  input  logic [31:0]       in_p3,
  input  logic [31:0]       in_p4,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [31:0]       out_result,
  output logic [PROD_W-1:0] out_product,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  import mul_pkg::*;

  // The stage-A bundle is sized by the package, so the parameters must agree.
  if (TAG_W != MUL_TAG_W || PROD_W != mul_pkg::PROD_W) begin : g_param_check
    $error("mul_product_combine: TAG_W/PROD_W must match mul_pkg");
  end

  stage_a_t         stage_a_q;
  stage_a_t         stage_a_d;
  logic [MID_W-1:0] mid_sum;
  logic [63:0]      mid_shifted;
  logic [63:0]      product_d;
  logic [31:0]      result_d;

  mul_mid_sum u_mid_sum (
    .p2        (in_p2),
    .p3        (in_p3),
    .p2_signed (in_src2_signed),
    .p3_signed (in_src1_signed),
    .mid       (mid_sum)
  );

  always_comb begin
    stage_a_d        = '0;
    stage_a_d.mid    = mid_sum;
    stage_a_d.hilo   = {in_p4, in_p1};
    stage_a_d.sel_hi = in_sel_hi;
    stage_a_d.tag    = in_tag;
    stage_a_d.valid  = in_valid;
  end

  // mid carries weight 2^16; the upper bits that fall off past bit 63 are
  // exactly the modulo-2^64 wrap of the full product.
  always_comb begin
    mid_shifted = {{(64-MID_W){stage_a_q.mid[MID_W-1]}}, stage_a_q.mid} << 16;
    product_d   = stage_a_q.hilo + mid_shifted;
    result_d    = select_word(product_d, stage_a_q.sel_hi);
  end

  // Priority is reset, then flush, then stall. Flush only touches the valid
  // bits; data may still advance when not stalled since it is don't-care.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_a_q   <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_product <= '0;
      out_tag     <= '0;
    end else begin
      if (!stall) begin
        stage_a_q   <= stage_a_d;
        out_valid   <= stage_a_q.valid;
        out_result  <= result_d;
        out_product <= product_d;
        out_tag     <= stage_a_q.tag;
      end
      if (flush) begin
        stage_a_q.valid <= 1'b0;
        out_valid       <= 1'b0;
      end
    end
  end

  assign busy = stage_a_q.valid | out_valid;

endmodule

// File: tb/tb_mul_product_combine.sv
// ---------------------------------------------------------------------------
// tb_mul_product_combine
//   Directed bench for mul_product_combine with hand-computed products.
// ---------------------------------------------------------------------------
module tb_mul_product_combine;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_src1_signed;
  logic        in_src2_signed;
  logic        in_sel_hi;
  logic [4:0]  in_tag;
  logic [31:0] in_p1;
  logic [31:0] in_p2;
  logic [31:0] in_p3;
  logic [31:0] in_p4;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_result;
  logic [63:0] out_product;
  logic [4:0]  out_tag;
  logic        busy;

  int checkCount = 0;
  int passCount  = 0;

  mul_product_combine #(.TAG_W(5), .PROD_W(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_src1_signed (in_src1_signed),
    .in_src2_signed (in_src2_signed),
    .in_sel_hi      (in_sel_hi),
    .in_tag         (in_tag),
    .in_p1          (in_p1),
    .in_p2          (in_p2),
    .in_p3          (in_p3),
    .in_p4          (in_p4),
    .stall          (stall),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_result     (out_result),
    .out_product    (out_product),
    .out_tag        (out_tag),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkEq(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
  endtask

  task automatic applyStimulus(input logic v, input logic s1, input logic s2, input logic sel,
                               input logic [4:0] tag, input logic [31:0] p1, input logic [31:0] p2,
                               input logic [31:0] p3, input logic [31:0] p4);
    in_valid       = v;
    in_src1_signed = s1;
    in_src2_signed = s2;
    in_sel_hi      = sel;
    in_tag         = tag;
    in_p1          = p1;
    in_p2          = p2;
    in_p3          = p3;
    in_p4          = p4;
  endtask

  // Idle cycles present X data to confirm it never leaks into the valid path.
  task automatic idle();
    in_valid       = 1'b0;
    in_src1_signed = 1'bx;
    in_src2_signed = 1'bx;
    in_sel_hi      = 1'bx;
    in_tag         = 'x;
    in_p1          = 'x;
    in_p2          = 'x;
    in_p3          = 'x;
    in_p4          = 'x;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expResult,
                             input logic [63:0] expProduct, input logic [4:0] expTag);
    checkEq({name, ".valid"},   {63'd0, out_valid}, 64'd1);
    checkEq({name, ".result"},  {32'd0, out_result}, {32'd0, expResult});
    checkEq({name, ".product"}, out_product, expProduct);
    checkEq({name, ".tag"},     {59'd0, out_tag}, {59'd0, expTag});
  endtask

  // Issue one op and verify the exact two-edge latency and one-cycle pulse.
  task automatic runOp(input string name, input logic s1, input logic s2, input logic sel,
                       input logic [4:0] tag, input logic [31:0] p1, input logic [31:0] p2,
                       input logic [31:0] p3, input logic [31:0] p4,
                       input logic [31:0] expResult, input logic [63:0] expProduct);
    applyStimulus(1'b1, s1, s2, sel, tag, p1, p2, p3, p4);
    tick();
    idle();
    checkEq({name, ".early_valid"}, {63'd0, out_valid}, 64'd0);
    checkEq({name, ".busy_a"},      {63'd0, busy}, 64'd1);
    tick();
    checkOutput(name, expResult, expProduct, tag);
    tick();
    checkEq({name, ".pulse_end"}, {63'd0, out_valid}, 64'd0);
    checkEq({name, ".idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    idle();
    tick();
    tick();
    checkEq("reset.valid",   {63'd0, out_valid}, 64'd0);
    checkEq("reset.result",  {32'd0, out_result}, 64'd0);
    checkEq("reset.product", out_product, 64'd0);
    checkEq("reset.tag",     {59'd0, out_tag}, 64'd0);
    checkEq("reset.busy",    {63'd0, busy}, 64'd0);
    reset_n = 1'b1;

    // 0xFFFFFFFF * 0xFFFFFFFF unsigned
    runOp("uu_hi", 1'b0, 1'b0, 1'b1, 5'd3, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001,
          32'hFFFFFFFE, 64'hFFFFFFFE_00000001);
    runOp("uu_lo", 1'b0, 1'b0, 1'b0, 5'd4, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001,
          32'h00000001, 64'hFFFFFFFE_00000001);
    // -1 * -1 signed
    runOp("ss_hi", 1'b1, 1'b1, 1'b1, 5'd5, 32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h00000001,
          32'h00000000, 64'h00000000_00000001);
    // -1 (signed) * 2 (unsigned)
    runOp("su_hi", 1'b1, 1'b0, 1'b1, 5'd6, 32'h0001FFFE, 32'h00000000, 32'hFFFFFFFE, 32'h00000000,
          32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFE);
    // us: p2 is -2^31, p3 is +2^31, so the cross terms cancel exactly
    runOp("us_lo", 1'b0, 1'b1, 1'b0, 5'd7, 32'h12345678, 32'h80000000, 32'h80000000, 32'h9ABCDEF0,
          32'h12345678, 64'h9ABCDEF0_12345678);

    // Back-to-back with a two-cycle stall after the second op
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0, 32'h0, 32'h0, 32'h1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001);
    tick();
    checkOutput("b2b.op1", 32'h1, 64'h00000001_00000000, 5'd1);
    stall = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd31, 32'h5, 32'h5, 32'h5, 32'h5);
    tick();
    checkOutput("b2b.stall1", 32'h1, 64'h00000001_00000000, 5'd1);
    tick();
    checkOutput("b2b.stall2", 32'h1, 64'h00000001_00000000, 5'd1);
    checkEq("b2b.stall_busy", {63'd0, busy}, 64'd1);
    stall = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h00000001);
    tick();
    idle();
    checkOutput("b2b.op2", 32'h1, 64'hFFFFFFFE_00000001, 5'd2);
    tick();
    checkOutput("b2b.op3", 32'h0, 64'h00000000_00000001, 5'd10);
    tick();
    checkEq("b2b.drain_valid", {63'd0, out_valid}, 64'd0);
    checkEq("b2b.drain_busy",  {63'd0, busy}, 64'd0);

    // Flush kills the op in stage A and the op presented alongside it
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h1, 32'h0, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h2, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    checkEq("flush.valid1", {63'd0, out_valid}, 64'd0);
    checkEq("flush.busy1",  {63'd0, busy}, 64'd0);
    tick();
    checkEq("flush.valid2", {63'd0, out_valid}, 64'd0);
    checkEq("flush.busy2",  {63'd0, busy}, 64'd0);

    // Flush together with stall still clears both stages
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 32'h3, 32'h0, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd13, 32'h4, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("fs.pre", 32'h3, 64'h3, 5'd12);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd14, 32'h5, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    stall = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    idle();
    checkEq("fs.valid1", {63'd0, out_valid}, 64'd0);
    checkEq("fs.busy1",  {63'd0, busy}, 64'd0);
    tick();
    checkEq("fs.valid2", {63'd0, out_valid}, 64'd0);

    // Reset in the middle of two ops discards both
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd20, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd21, 32'h7, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("rst.pre", 32'hFFFFFFFE, 64'hFFFFFFFE_00000001, 5'd20);
    idle();
    reset_n = 1'b0;
    stall   = 1'b1;
    tick();
    reset_n = 1'b1;
    stall   = 1'b0;
    checkEq("rst.valid",   {63'd0, out_valid}, 64'd0);
    checkEq("rst.result",  {32'd0, out_result}, 64'd0);
    checkEq("rst.product", out_product, 64'd0);
    checkEq("rst.tag",     {59'd0, out_tag}, 64'd0);
    checkEq("rst.busy",    {63'd0, busy}, 64'd0);
    tick();
    checkEq("rst.after1", {63'd0, out_valid}, 64'd0);
    tick();
    checkEq("rst.after2", {63'd0, out_valid}, 64'd0);

    runOp("post_rst", 1'b1, 1'b1, 1'b1, 5'd22, 32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h00000001,
          32'h00000000, 64'h00000000_00000001);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
